snake_input_ctrl: RTL and testbench

SNAKE_INPUT_CTRL -- requirements
Module: snake_input_ctrl

---
 rtl/snake_input_ctrl.sv | 159 +++++++++++++++
 tb/tb_snake_input_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl
//   Turns four raw, bouncy direction buttons into a committed snake heading.
//   Each button goes through a 2-flop synchronizer and its own debouncer.
//   A 0->1 debounced edge is a press event. Simultaneous presses resolve as
//   U > D > L > R. A request is accepted only if it turns the snake: it must
//   be neither the reference heading nor its reverse. An accepted request is
//   held as pending (last one wins) and is committed on the next move tick.
//
// Parameters
//   DB_CYCLES   : consecutive stable cycles needed to accept a level change (>= 1)
//   TICK_PERIOD : clock cycles per move tick (>= 2)
//
// Ports
//   Clk        in   single clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Run        in   game running; gates press events, tick counter and pending
//   BtnU/D/L/R in   raw asynchronous buttons
//   Dir        out  committed heading: 00 up, 01 down, 10 left, 11 right
//   MoveTick   out  one-cycle pulse per snake step
//   DirChanged out  one-cycle pulse together with MoveTick when Dir was updated
//   Pending    out  a direction request is stored and awaits the next tick
module snake_input_ctrl #(
  parameter int DB_CYCLES   = 4,
  parameter int TICK_PERIOD = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic [1:0] Dir,
  output logic       MoveTick,
  output logic       DirChanged,
  output logic       Pending
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(TICK_PERIOD);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Bit order of all per-button vectors: [3]=U, [2]=D, [1]=L, [0]=R.
  function automatic logic [1:0] prio_dir(input logic [3:0] ev);
    if (ev[3])      prio_dir = DIR_UP;
    else if (ev[2]) prio_dir = DIR_DOWN;
    else if (ev[1]) prio_dir = DIR_LEFT;
    else            prio_dir = DIR_RIGHT;
  endfunction

  // Same heading and reverse heading share the axis bit (U/D = 0x, L/R = 1x),
  // so a request is a real turn exactly when the axis bit differs.
  function automatic logic is_turn(input logic [1:0] req, input logic [1:0] ref_dir);
    is_turn = (req[1] != ref_dir[1]);
  endfunction

  logic [3:0]           btn_raw;
  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           deb_q, deb_d;
  logic [3:0][DBW-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]           press_q, press_d;

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 tick_q, tick_d;
  logic                 chg_q, chg_d;
  logic                 pend_q, pend_d;
  logic [1:0]           pend_dir_q, pend_dir_d;
  logic [1:0]           dir_q, dir_d;

  logic                 req_vld;
  logic [1:0]           req_dir;
  logic                 commit;
  logic [1:0]           ref_dir;
  logic                 accept;

  assign btn_raw = {BtnU, BtnD, BtnL, BtnR};

  // ---- debounce: a counter runs only while synced and debounced levels differ
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    press_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
        press_d[i]  = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  // ---- request resolution and commit
  always_comb begin
    req_vld = Run && (press_q != 4'b0000);
    req_dir = prio_dir(press_q);

    tick_d  = Run && (tick_cnt_q == TW'(TICK_PERIOD - 1));
    commit  = tick_d && pend_q;

    // On a commit edge the new request is judged against the heading that is
    // about to take effect, not the one being replaced.
    ref_dir = commit ? pend_dir_q : dir_q;
    accept  = req_vld && is_turn(req_dir, ref_dir);

    tick_cnt_d = '0;
    if (Run && !tick_d) tick_cnt_d = tick_cnt_q + TW'(1);

    dir_d      = commit ? pend_dir_q : dir_q;
    chg_d      = commit;
    pend_dir_d = accept ? req_dir : pend_dir_q;

    if (!Run)        pend_d = 1'b0;
    else if (accept) pend_d = 1'b1;
    else if (commit) pend_d = 1'b0;
    else             pend_d = pend_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      db_cnt_q   <= '0;
      press_q    <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      chg_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_dir_q <= 2'b00;
      dir_q      <= DIR_RIGHT;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      chg_q      <= chg_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      dir_q      <= dir_d;
    end
  end

  assign Dir        = dir_q;
  assign MoveTick   = tick_q;
  assign DirChanged = chg_q;
  assign Pending    = pend_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl (DB_CYCLES=4, TICK_PERIOD=16).
// Expected move ticks are queued with their cycle, heading and DirChanged
// value when the stimulus is planned; every clock the observed tick is
// matched against the queue head.
module tb_snake_input_ctrl;

  localparam int TP = 16;

  logic       Clk = 1'b0;
  logic       Reset, Run, BtnU, BtnD, BtnL, BtnR;
  logic [1:0] Dir;
  logic       MoveTick, DirChanged, Pending;

  snake_input_ctrl #(.DB_CYCLES(4), .TICK_PERIOD(TP)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .Dir(Dir), .MoveTick(MoveTick), .DirChanged(DirChanged), .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic [1:0] dir;
    logic       dc;
  } tick_t;

  tick_t q[$];
  int    cyc   = 0;
  int    nt    = 1 << 30;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    tick_t e;
    @(posedge Clk);
    #1;
    cyc++;
    chk("dirchanged_only_with_tick", 32'(DirChanged & ~MoveTick), 32'd0);
    if (MoveTick !== 1'b0 || (q.size() != 0 && q[0].cyc <= cyc)) begin
      chk("movetick", 32'(MoveTick), 32'd1);
      chk("tick_queued", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("tick_cycle", 32'(cyc), 32'(e.cyc));
        chk("tick_dir", 32'(Dir), 32'(e.dir));
        chk("tick_dirchanged", 32'(DirChanged), 32'(e.dc));
      end
    end
  endtask

  task automatic sched(input logic [1:0] d, input logic c);
    q.push_back('{cyc: nt, dir: d, dc: c});
    nt += TP;
  endtask

  // Queue every tick falling inside the next n cycles with heading d, then run.
  task automatic advance(input int n, input logic [1:0] d);
    while (nt <= cyc + n) sched(d, 1'b0);
    repeat (n) step();
  endtask

  initial begin
    int t;
    Reset = 1'b1; Run = 1'b0;
    BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_dir", 32'(Dir), 32'd3);
    chk("rst_pending", 32'(Pending), 32'd0);
    chk("rst_movetick", 32'(MoveTick), 32'd0);
    chk("rst_dirchanged", 32'(DirChanged), 32'd0);
    Reset = 1'b0;
    repeat (4) step();

    // free-running ticks at 16, 32, 48 after Run rises
    Run = 1'b1;
    nt  = cyc + TP;
    advance(48, 2'b11);
    chk("idle_dir", 32'(Dir), 32'd3);

    // BtnU from right: pending at cycle 7, committed on next tick
    BtnU = 1'b1;
    advance(6, 2'b11);
    chk("u_pending_c6", 32'(Pending), 32'd0);
    advance(1, 2'b11);
    chk("u_pending_c7", 32'(Pending), 32'd1);
    chk("u_dir_before", 32'(Dir), 32'd3);
    advance(3, 2'b11);
    BtnU = 1'b0;
    t = nt; sched(2'b00, 1'b1);
    advance(t - cyc + 1, 2'b00);
    chk("u_dir_after", 32'(Dir), 32'd0);
    chk("u_pending_after", 32'(Pending), 32'd0);

    // BtnR from up: turns back to right
    BtnR = 1'b1;
    advance(7, 2'b00);
    chk("r_pending", 32'(Pending), 32'd1);
    advance(3, 2'b00);
    BtnR = 1'b0;
    t = nt; sched(2'b11, 1'b1);
    advance(t - cyc + 1, 2'b11);
    chk("r_dir_after", 32'(Dir), 32'd3);

    // BtnL (reverse) then BtnR (same) from right: both rejected over two ticks
    BtnL = 1'b1;
    advance(7, 2'b11);
    chk("l_rej_pending_c7", 32'(Pending), 32'd0);
    advance(3, 2'b11);
    chk("l_rej_pending_c10", 32'(Pending), 32'd0);
    BtnL = 1'b0;
    advance(nt + TP - cyc + 1, 2'b11);
    chk("l_rej_pending_end", 32'(Pending), 32'd0);
    chk("l_rej_dir", 32'(Dir), 32'd3);
    BtnR = 1'b1;
    advance(7, 2'b11);
    chk("r_rej_pending_c7", 32'(Pending), 32'd0);
    advance(3, 2'b11);
    BtnR = 1'b0;
    advance(nt + TP - cyc + 1, 2'b11);
    chk("r_rej_pending_end", 32'(Pending), 32'd0);
    chk("r_rej_dir", 32'(Dir), 32'd3);

    // BtnD bouncing every 2 cycles never settles: no event
    for (int i = 0; i < 5; i++) begin
      BtnD = 1'b1;
      advance(2, 2'b11);
      BtnD = 1'b0;
      advance(2, 2'b11);
      chk("bounce_pending", 32'(Pending), 32'd0);
    end
    advance(10, 2'b11);
    chk("bounce_pending_end", 32'(Pending), 32'd0);
    advance(nt - cyc + 1, 2'b11);
    chk("bounce_dir", 32'(Dir), 32'd3);

    // U and D together: U wins
    BtnU = 1'b1; BtnD = 1'b1;
    advance(7, 2'b11);
    chk("ud_pending", 32'(Pending), 32'd1);
    advance(3, 2'b11);
    BtnU = 1'b0; BtnD = 1'b0;
    t = nt; sched(2'b00, 1'b1);
    advance(t - cyc + 1, 2'b00);
    chk("ud_dir", 32'(Dir), 32'd0);
    chk("ud_pending_after", 32'(Pending), 32'd0);

    // reset mid-tick (counter at 9) with a request pending
    BtnL = 1'b1;
    advance(7, 2'b00);
    chk("mid_pending", 32'(Pending), 32'd1);
    advance(1, 2'b00);
    BtnL = 1'b0;
    Reset = 1'b1;
    step();
    chk("mid_rst_dir", 32'(Dir), 32'd3);
    chk("mid_rst_pending", 32'(Pending), 32'd0);
    chk("mid_rst_movetick", 32'(MoveTick), 32'd0);
    Reset = 1'b0;
    nt = cyc + TP;
    advance(17, 2'b11);
    chk("post_rst_dir", 32'(Dir), 32'd3);

    // Run=0 clears pending, stops ticks and ignores presses
    BtnU = 1'b1;
    advance(7, 2'b11);
    chk("run_pending", 32'(Pending), 32'd1);
    advance(3, 2'b11);
    BtnU = 1'b0;
    Run = 1'b0;
    step();
    chk("stop_pending_cleared", 32'(Pending), 32'd0);
    BtnD = 1'b1;
    repeat (10) step();
    chk("stop_press_ignored", 32'(Pending), 32'd0);
    BtnD = 1'b0;
    repeat (10) step();
    Run = 1'b1;
    nt = cyc + TP;
    advance(17, 2'b11);
    chk("restart_dir", 32'(Dir), 32'd3);
    chk("restart_pending", 32'(Pending), 32'd0);

    chk("ticks_all_seen", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
